reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/cpu_pkg.sv | 14 +
 rtl/reg_file_sb_counter.sv | 52 +++++
 rtl/reg_file_sb.sv | 107 ++++++++++
 tb/tb_reg_file_sb.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared defaults for the register file / scoreboard slice.
//   DATA_WIDTH_DEF : register data width
//   REG_WIDTH_DEF  : register address width (2**REG_WIDTH_DEF registers)
//   CNT_WIDTH_DEF  : width of each per-register in-flight write counter
//   regAddr_t      : register address type at the default width
package cpu_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int REG_WIDTH_DEF  = 4;
  localparam int CNT_WIDTH_DEF  = 2;

  typedef logic [REG_WIDTH_DEF-1:0] regAddr_t;

endpackage

// File: rtl/reg_file_sb_counter.sv
// sb_counter: one saturating up/down counter tracking in-flight writes to a
// single register.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears the count
//   inc  : one new in-flight write this cycle
//   dec  : number of writes retired or cancelled this cycle (0..2)
//   cnt  : current count
//   err  : this cycle's update would overflow or underflow (combinational)
module sb_counter
#(
  parameter int CNT_WIDTH = 2
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic [1:0]           dec,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 err
);

  // Two guard bits let cnt+1 and cnt+inc-dec be evaluated without wrapping.
  localparam int W = CNT_WIDTH + 2;
  localparam logic [W-1:0] CNT_MAX = W'((2**CNT_WIDTH) - 1);

  logic [W-1:0] sum;
  logic [W-1:0] diff;
  logic         under;
  logic         over;

  always_comb begin
    sum   = W'(cnt) + W'(inc);
    under = sum < W'(dec);
    diff  = sum - W'(dec);
    over  = !under && (diff > CNT_MAX);
    err   = under | over;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (under) begin
      cnt <= '0;
    end else if (over) begin
      cnt <= CNT_MAX[CNT_WIDTH-1:0];
    end else begin
      cnt <= diff[CNT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with a per-register write scoreboard that
// stalls ID while a consumed source register still has writes in flight.
// Optional feature macro: RF_BYPASS_EN -- forwards the WB result onto the
// read ports in the same cycle and lets that write retire the stall early.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   RegWriteW_i/WriteRegW_i/ResultW_i : writeback enable, register, data
//   rs_addr_i/rt_addr_i             : read addresses
//   rs_use_i/rt_use_i               : ID instruction consumes that port
//   issue_i/issue_reg_i             : instruction leaving ID with a pending write
//   cancel_i/cancel_reg_i           : squashed in-flight write
//   rs_data_o/rt_data_o             : combinational read data
//   stall_o                         : a used source has a pending write
//   sb_err_o                        : sticky scoreboard over/underflow flag
module reg_file_sb
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int REG_WIDTH  = REG_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteW_i,
  input  logic [REG_WIDTH-1:0]  WriteRegW_i,
  input  logic [DATA_WIDTH-1:0] ResultW_i,
  input  logic [REG_WIDTH-1:0]  rs_addr_i,
  input  logic [REG_WIDTH-1:0]  rt_addr_i,
  input  logic                  rs_use_i,
  input  logic                  rt_use_i,
  input  logic                  issue_i,
  input  logic [REG_WIDTH-1:0]  issue_reg_i,
  input  logic                  cancel_i,
  input  logic [REG_WIDTH-1:0]  cancel_reg_i,
  output logic [DATA_WIDTH-1:0] rs_data_o,
  output logic [DATA_WIDTH-1:0] rt_data_o,
  output logic                  stall_o,
  output logic                  sb_err_o
);

  localparam int NUM_REGS = 2**REG_WIDTH;

  logic [DATA_WIDTH-1:0] regMem [NUM_REGS];
  logic [CNT_WIDTH-1:0]  cntArr [NUM_REGS];
  logic [NUM_REGS-1:0]   incVec;
  logic [NUM_REGS-1:0]   wbHit;
  logic [NUM_REGS-1:0]   cancelHit;
  logic [NUM_REGS-1:0]   errVec;
  logic                  rsBusy;
  logic                  rtBusy;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regMem[r] <= '0;
      end
    end else if (RegWriteW_i) begin
      regMem[WriteRegW_i] <= ResultW_i;
    end
  end

  always_comb begin
`ifdef RF_BYPASS_EN
    rs_data_o = (RegWriteW_i && (WriteRegW_i == rs_addr_i)) ? ResultW_i : regMem[rs_addr_i];
    rt_data_o = (RegWriteW_i && (WriteRegW_i == rt_addr_i)) ? ResultW_i : regMem[rt_addr_i];
    // A write retiring this cycle is already visible on the read port, so it
    // no longer counts as pending for the reader.
    rsBusy = cntArr[rs_addr_i] > CNT_WIDTH'(wbHit[rs_addr_i]);
    rtBusy = cntArr[rt_addr_i] > CNT_WIDTH'(wbHit[rt_addr_i]);
`else
    rs_data_o = regMem[rs_addr_i];
    rt_data_o = regMem[rt_addr_i];
    rsBusy    = cntArr[rs_addr_i] != '0;
    rtBusy    = cntArr[rt_addr_i] != '0;
`endif
  end

  assign stall_o = (rs_use_i & rsBusy) | (rt_use_i & rtBusy);

  for (genvar r = 0; r < NUM_REGS; r++) begin : gCnt
    assign incVec[r]    = issue_i & (issue_reg_i == REG_WIDTH'(r)) & ~stall_o;
    assign wbHit[r]     = RegWriteW_i & (WriteRegW_i == REG_WIDTH'(r));
    assign cancelHit[r] = cancel_i & (cancel_reg_i == REG_WIDTH'(r));

    sb_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) uCnt (
      .clk (clk),
      .rst (rst),
      .inc (incVec[r]),
      // WB and cancel may both retire a write to the same register.
      .dec ({wbHit[r] & cancelHit[r], wbHit[r] ^ cancelHit[r]}),
      .cnt (cntArr[r]),
      .err (errVec[r])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err_o <= 1'b0;
    end else if (|errVec) begin
      sb_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed scoreboard bench for reg_file_sb. The stimulus
// process drives one cycle of inputs and queues the outputs it expects for
// that cycle; the monitor pops and compares them on the falling edge.
module tb_reg_file_sb;

  localparam int DW = 16;
  localparam int RW = 4;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          RegWriteW_i;
  logic [RW-1:0] WriteRegW_i;
  logic [DW-1:0] ResultW_i;
  logic [RW-1:0] rs_addr_i;
  logic [RW-1:0] rt_addr_i;
  logic          rs_use_i;
  logic          rt_use_i;
  logic          issue_i;
  logic [RW-1:0] issue_reg_i;
  logic          cancel_i;
  logic [RW-1:0] cancel_reg_i;
  logic [DW-1:0] rs_data_o;
  logic [DW-1:0] rt_data_o;
  logic          stall_o;
  logic          sb_err_o;

  reg_file_sb dut (
    .clk          (clk),
    .rst          (rst),
    .RegWriteW_i  (RegWriteW_i),
    .WriteRegW_i  (WriteRegW_i),
    .ResultW_i    (ResultW_i),
    .rs_addr_i    (rs_addr_i),
    .rt_addr_i    (rt_addr_i),
    .rs_use_i     (rs_use_i),
    .rt_use_i     (rt_use_i),
    .issue_i      (issue_i),
    .issue_reg_i  (issue_reg_i),
    .cancel_i     (cancel_i),
    .cancel_reg_i (cancel_reg_i),
    .rs_data_o    (rs_data_o),
    .rt_data_o    (rt_data_o),
    .stall_o      (stall_o),
    .sb_err_o     (sb_err_o)
  );

  always #5 clk = ~clk;

  // kind: 0 rs_data, 1 rt_data, 2 stall, 3 sb_err
  typedef struct packed {
    logic [1:0]    kind;
    logic [DW-1:0] val;
  } expItem_t;

  expItem_t expQ[$];
  string    nameQ[$];
  int       checks   = 0;
  int       failures = 0;

  task automatic expect_out(input logic [1:0] kind, input logic [DW-1:0] val, input string name);
    expItem_t e;
    e.kind = kind;
    e.val  = val;
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  always @(negedge clk) begin
    expItem_t      e;
    string         nm;
    logic [DW-1:0] act;
    while (expQ.size() > 0) begin
      e  = expQ.pop_front();
      nm = nameQ.pop_front();
      case (e.kind)
        2'd0:    act = rs_data_o;
        2'd1:    act = rt_data_o;
        2'd2:    act = DW'(stall_o);
        default: act = DW'(sb_err_o);
      endcase
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, e.val, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst          = 1'b0;
    RegWriteW_i  = 1'b0;
    WriteRegW_i  = '0;
    ResultW_i    = '0;
    rs_addr_i    = '0;
    rt_addr_i    = '0;
    rs_use_i     = 1'b0;
    rt_use_i     = 1'b0;
    issue_i      = 1'b0;
    issue_reg_i  = '0;
    cancel_i     = 1'b0;
    cancel_reg_i = '0;
  endtask

  task automatic do_issue(input logic [RW-1:0] r);
    idle();
    issue_i     = 1'b1;
    issue_reg_i = r;
    tick();
  endtask

  task automatic do_wb(input logic [RW-1:0] r, input logic [DW-1:0] d);
    idle();
    RegWriteW_i = 1'b1;
    WriteRegW_i = r;
    ResultW_i   = d;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b1;
    tick();

    // Reset state: every register reads 0 on both ports, no stall, no error.
    for (int r = 0; r < 16; r++) begin
      idle();
      rs_addr_i = RW'(r);
      rt_addr_i = RW'(15 - r);
      rs_use_i  = 1'b1;
      rt_use_i  = 1'b1;
      expect_out(2'd0, 16'h0000, "reset_rs_data");
      expect_out(2'd1, 16'h0000, "reset_rt_data");
      expect_out(2'd2, 16'h0000, "reset_stall");
      expect_out(2'd3, 16'h0000, "reset_err");
      tick();
    end

    // Plain write/read: R3=0x1234 then R4=0x5A5A.
    do_issue(4'd3);
    idle();
    RegWriteW_i = 1'b1; WriteRegW_i = 4'd3; ResultW_i = 16'h1234;
    issue_i = 1'b1; issue_reg_i = 4'd4;
    rs_addr_i = 4'd3;
    expect_out(2'd0, BYP ? 16'h1234 : 16'h0000, "wb_cycle_rs_r3");
    tick();
    idle();
    RegWriteW_i = 1'b1; WriteRegW_i = 4'd4; ResultW_i = 16'h5A5A;
    rs_addr_i = 4'd3; rt_addr_i = 4'd4;
    expect_out(2'd0, 16'h1234, "read_r3");
    expect_out(2'd1, BYP ? 16'h5A5A : 16'h0000, "wb_cycle_rt_r4");
    tick();
    idle();
    rs_addr_i = 4'd4; rt_addr_i = 4'd4; rs_use_i = 1'b1; rt_use_i = 1'b1;
    expect_out(2'd0, 16'h5A5A, "read_rs_r4");
    expect_out(2'd1, 16'h5A5A, "read_rt_r4");
    expect_out(2'd2, 16'h0000, "r4_no_stall");
    expect_out(2'd3, 16'h0000, "write_no_err");
    tick();

    // Stall on pending R5 until WB; an issue while stalled is ignored.
    idle();
    issue_i = 1'b1; issue_reg_i = 4'd5;
    expect_out(2'd2, 16'h0000, "issue_r5_no_stall");
    tick();
    idle();
    rs_addr_i = 4'd5; rs_use_i = 1'b1;
    expect_out(2'd2, 16'h0001, "r5_stall_rs");
    tick();
    idle();
    rt_addr_i = 4'd5; rt_use_i = 1'b1; rs_addr_i = 4'd5;
    expect_out(2'd2, 16'h0001, "r5_stall_rt");
    tick();
    idle();
    rs_addr_i = 4'd5; rs_use_i = 1'b1; issue_i = 1'b1; issue_reg_i = 4'd6;
    expect_out(2'd2, 16'h0001, "r5_stall_issue_r6");
    tick();
    idle();
    RegWriteW_i = 1'b1; WriteRegW_i = 4'd5; ResultW_i = 16'hBEEF;
    rs_addr_i = 4'd5; rs_use_i = 1'b1;
    expect_out(2'd2, BYP ? 16'h0000 : 16'h0001, "r5_wb_cycle_stall");
    expect_out(2'd0, BYP ? 16'hBEEF : 16'h0000, "r5_wb_cycle_data");
    tick();
    idle();
    rs_addr_i = 4'd5; rs_use_i = 1'b1;
    expect_out(2'd2, 16'h0000, "r5_after_wb_stall");
    expect_out(2'd0, 16'hBEEF, "r5_after_wb_data");
    tick();
    idle();
    rs_addr_i = 4'd6; rs_use_i = 1'b1;
    expect_out(2'd2, 16'h0000, "stalled_issue_ignored");
    tick();

    // Same-cycle issue and WB on R7 leaves the count at 1.
    do_issue(4'd7);
    idle();
    issue_i = 1'b1; issue_reg_i = 4'd7;
    RegWriteW_i = 1'b1; WriteRegW_i = 4'd7; ResultW_i = 16'h0777;
    tick();
    idle();
    rs_addr_i = 4'd7; rs_use_i = 1'b1;
    expect_out(2'd2, 16'h0001, "r7_inc_dec_stall");
    expect_out(2'd0, 16'h0777, "r7_first_data");
    tick();
    idle();
    RegWriteW_i = 1'b1; WriteRegW_i = 4'd7; ResultW_i = 16'h7777;
    rs_addr_i = 4'd7; rs_use_i = 1'b1;
    expect_out(2'd2, BYP ? 16'h0000 : 16'h0001, "r7_second_wb_stall");
    tick();
    idle();
    rs_addr_i = 4'd7; rs_use_i = 1'b1;
    expect_out(2'd2, 16'h0000, "r7_cleared");
    expect_out(2'd0, 16'h7777, "r7_second_data");
    expect_out(2'd3, 16'h0000, "r7_no_err");
    tick();

    // Cancel retires a pending write.
    do_issue(4'd9);
    idle();
    cancel_i = 1'b1; cancel_reg_i = 4'd9;
    rs_addr_i = 4'd9; rs_use_i = 1'b1;
    expect_out(2'd2, 16'h0001, "r9_cancel_cycle_stall");
    tick();
    idle();
    rs_addr_i = 4'd9; rs_use_i = 1'b1;
    expect_out(2'd2, 16'h0000, "r9_cancelled");
    expect_out(2'd3, 16'h0000, "cancel_no_err");
    tick();

    // Reset mid-operation with cnt[4]=2.
    do_issue(4'd4);
    do_issue(4'd4);
    idle();
    rst = 1'b1; rs_addr_i = 4'd4; rs_use_i = 1'b1;
    expect_out(2'd2, 16'h0001, "r4_cnt2_stall");
    tick();
    idle();
    rs_addr_i = 4'd4; rs_use_i = 1'b1; rt_addr_i = 4'd3;
    expect_out(2'd2, 16'h0000, "rst_clears_cnt");
    expect_out(2'd0, 16'h0000, "rst_clears_r4");
    expect_out(2'd1, 16'h0000, "rst_clears_r3");
    tick();

    // Overflow: four issues of R2 saturate at 3 and set the error.
    do_issue(4'd2);
    do_issue(4'd2);
    do_issue(4'd2);
    idle();
    issue_i = 1'b1; issue_reg_i = 4'd2;
    expect_out(2'd3, 16'h0000, "err_before_overflow");
    tick();
    idle();
    rs_addr_i = 4'd2; rs_use_i = 1'b1;
    expect_out(2'd3, 16'h0001, "overflow_err");
    expect_out(2'd2, 16'h0001, "overflow_stall");
    tick();
    do_wb(4'd2, 16'h0002);
    do_wb(4'd2, 16'h0002);
    idle();
    rs_addr_i = 4'd2; rs_use_i = 1'b1;
    expect_out(2'd2, 16'h0001, "saturated_cnt_still_1");
    tick();
    do_wb(4'd2, 16'h0222);
    idle();
    rs_addr_i = 4'd2; rs_use_i = 1'b1;
    expect_out(2'd2, 16'h0000, "saturated_cnt_drained");
    expect_out(2'd0, 16'h0222, "r2_data");
    expect_out(2'd3, 16'h0001, "err_sticky");
    tick();

    // Underflow after a fresh reset.
    idle();
    rst = 1'b1;
    tick();
    idle();
    expect_out(2'd3, 16'h0000, "err_cleared_by_rst");
    tick();
    do_wb(4'd2, 16'h0055);
    idle();
    rs_addr_i = 4'd2; rs_use_i = 1'b1;
    expect_out(2'd3, 16'h0001, "underflow_err");
    expect_out(2'd2, 16'h0000, "underflow_clamped");
    tick();
    idle();
    tick();
    idle();
    expect_out(2'd3, 16'h0001, "underflow_err_sticky");
    tick();

    idle();
    rs_addr_i = 4'd2; rs_use_i = 1'b1; rt_addr_i = 4'd2;
    #1;
    checks++;
    if (rs_data_o !== 16'h0055) begin
      failures++;
      $display("FAIL final_rs_r2: got 0x%0h expected 0x55 at %0t", rs_data_o, $time);
    end
    checks++;
    if (rt_data_o !== 16'h0055) begin
      failures++;
      $display("FAIL final_rt_r2: got 0x%0h expected 0x55 at %0t", rt_data_o, $time);
    end
    checks++;
    if (stall_o !== 1'b0) begin
      failures++;
      $display("FAIL final_stall: got %0b expected 0 at %0t", stall_o, $time);
    end
    checks++;
    if (sb_err_o !== 1'b1) begin
      failures++;
      $display("FAIL final_err: got %0b expected 1 at %0t", sb_err_o, $time);
    end
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
